// File: rtl/crypto_sched_pkg.sv
// Shared widths, default timeout and FSM state encoding for the crypto core scheduler.
package crypto_sched_pkg;

    localparam int DATA_W          = 128;
    localparam int KEY_W           = 256;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RESP,
        ZERO
    } sched_state_t;

endpackage

// File: rtl/crypto_core_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps, returning a one-hot grant and its index.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    always_comb begin
        int          j;
        logic [IW-1:0] idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            idx = IW'(j);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign grant_any = |req;

endmodule

// File: rtl/crypto_core_sched.sv
// Shares one cipher core among N_REQ requesters: round-robin grant, one-shot start, RUN timeout, held response.
// Define SCHED_KEY_ZEROIZE_EN to add a one-cycle ZERO state that wipes key/data/result buffers after each response.
module crypto_core_sched
    import crypto_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ*KEY_W-1:0]   req_key,
    output logic                     core_start,
    output logic [DATA_W-1:0]        core_data,
    output logic [KEY_W-1:0]         core_key,
    input  logic                     core_done,
    input  logic [DATA_W-1:0]        core_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_error,
    output logic                     busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    sched_state_t      state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, grant_idx, id_buf;
    logic [N_REQ-1:0]  grant_oh;
    logic              grant_any;
    logic [DATA_W-1:0] data_buf, result_buf;
    logic [KEY_W-1:0]  key_buf;
    logic              error_buf;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              timeout_hit;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The budget runs from core_start, so the LOAD cycle counts toward TIMEOUT.
    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        core_data  = '0;
        core_key   = '0;
        rsp_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!rst) begin
                    req_ready = grant_oh;
                end
                if (grant_any) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!rst) begin
                    core_start = 1'b1;
                    core_data  = data_buf;
                    core_key   = key_buf;
                end
                state_nxt = RUN;
            end
            RUN: begin
                if (core_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
`ifdef SCHED_KEY_ZEROIZE_EN
                    state_nxt = ZERO;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            ZERO:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            cnt        <= '0;
            data_buf   <= '0;
            key_buf    <= '0;
            id_buf     <= '0;
            result_buf <= '0;
            error_buf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        data_buf <= req_data[grant_idx*DATA_W +: DATA_W];
                        key_buf  <= req_key[grant_idx*KEY_W +: KEY_W];
                        id_buf   <= grant_idx;
                        rr_ptr   <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    end
                end
                LOAD: cnt <= '0;
                RUN: begin
                    // A completion landing on the timeout cycle still wins.
                    if (core_done) begin
                        result_buf <= core_result;
                        error_buf  <= 1'b0;
                    end else if (timeout_hit) begin
                        result_buf <= '0;
                        error_buf  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`ifdef SCHED_KEY_ZEROIZE_EN
                ZERO: begin
                    data_buf   <= '0;
                    key_buf    <= '0;
                    result_buf <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign rsp_id    = id_buf;
    assign rsp_data  = result_buf;
    assign rsp_error = error_buf;

endmodule

// File: tb/tb_crypto_core_sched.sv
// Scoreboard bench for crypto_core_sched: behavioural core model, round-robin reference and response queue.
module tb_crypto_core_sched;
    import crypto_sched_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 64;

    typedef struct packed {
        logic [1:0]   id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready;
    logic [N*128-1:0] req_data;
    logic [N*256-1:0] req_key;
    logic             core_start, core_done;
    logic [127:0]     core_data, core_result;
    logic [255:0]     core_key;
    logic             rsp_valid, rsp_ready, rsp_error, busy;
    logic [1:0]       rsp_id;
    logic [127:0]     rsp_data;

    exp_t         sb[$];
    int           grant_log[$];
    int           exp_order[5] = '{0, 1, 2, 3, 0};
    int           n_tests = 0, n_fail = 0;
    int           cyc = 0, t_grant = 0, t_start = 0, t_done = 0;
    int           n_grants = 0, n_starts = 0, n_rsp = 0;
    int           core_delay, model_ptr = 0, ccnt = 0;
    logic         model_busy = 1'b0, model_zero = 1'b0, zchk = 1'b0, pending = 1'b0, prev_rsp = 1'b0;
    logic         hold_req;
    logic [N-1:0] grant_clr;
    logic [1:0]   last_id;
    logic [127:0] last_data, res_hold;
    logic         last_err;

    always #5 clk = ~clk;

    crypto_core_sched #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_key     (req_key),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .busy        (busy)
    );

    function automatic logic [127:0] mix(input logic [127:0] d, input logic [255:0] k);
        return d ^ k[127:0] ^ k[255:128];
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!hold_req) req_valid = req_valid & ~grant_clr;
            grant_clr = '0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        tick(1);
        while ((req_valid != 0 || sb.size() != 0 || model_busy) && b > 0) begin
            tick(1);
            b--;
        end
        check("idle_reached", (req_valid != 0 || sb.size() != 0 || model_busy), 0);
    endtask

    // Reference model and core model, sampled on the falling edge.
    initial begin : monitor
        logic [N-1:0] exp_ready;
        int           g;
        exp_t         e;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            cyc++;
            core_done = 1'b0;
            exp_ready = '0;
            g         = -1;
            if (rst) begin
                sb.delete();
                model_busy = 1'b0; model_ptr = 0; model_zero = 1'b0; zchk = 1'b0;
                pending    = 1'b0; prev_rsp = 1'b0;
            end else begin
                check("busy", busy, model_busy);
                if (!model_busy && req_valid != 0) begin
                    for (int i = 0; i < N; i++) begin
                        int j;
                        j = (model_ptr + i) % N;
                        if (g < 0 && req_valid[j]) g = j;
                    end
                    exp_ready[g] = 1'b1;
                end
                check("req_ready", req_ready, exp_ready);
                for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);

                if (core_start) begin
                    check("start_lat", cyc - t_grant, 1);
                    t_start  = cyc;
                    n_starts++;
                    res_hold = mix(core_data, core_key);
                    pending  = (core_delay > 0);
                    ccnt     = core_delay;
                end else begin
                    check("core_idle_zero", {|core_data, |core_key}, 0);
                end

`ifdef SCHED_KEY_ZEROIZE_EN
                if (zchk) begin
                    check("zero_key_buf", dut.key_buf, 0);
                    check("zero_data_buf", dut.data_buf, 0);
                    check("zero_result_buf", dut.result_buf, 0);
                    zchk = 1'b0;
                end
                if (model_zero) begin
                    check("zero_state", dut.state, ZERO);
                    model_zero = 1'b0;
                    model_busy = 1'b0;
                    zchk       = 1'b1;
                end
`endif

                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        if (!prev_rsp) begin
                            if (sb[0].err) check("tmo_lat", cyc - t_start, TMO);
                            else           check("done_lat", cyc - t_done, 1);
                        end
                        if (rsp_ready) begin
                            e = sb.pop_front();
                            check("rsp_id", rsp_id, e.id);
                            check("rsp_data", rsp_data, e.data);
                            check("rsp_error", rsp_error, e.err);
                            last_id   = rsp_id;
                            last_data = rsp_data;
                            last_err  = rsp_error;
                            n_rsp++;
`ifdef SCHED_KEY_ZEROIZE_EN
                            model_zero = 1'b1;
`else
                            model_busy = 1'b0;
`endif
                        end
                    end
                end
                prev_rsp = rsp_valid && !rsp_ready;

                if (g >= 0) begin
                    e.id   = 2'(g);
                    e.err  = (core_delay <= 0 || core_delay >= TMO);
                    e.data = e.err ? '0 : mix(req_data[g*128 +: 128], req_key[g*256 +: 256]);
                    sb.push_back(e);
                    model_ptr    = (g + 1) % N;
                    model_busy   = 1'b1;
                    t_grant      = cyc;
                    grant_clr[g] = 1'b1;
                    n_grants++;
                end

                if (!core_start && pending) begin
                    ccnt--;
                    if (ccnt == 0) begin
                        core_done = 1'b1;
                        pending   = 1'b0;
                        t_done    = cyc;
                    end
                end
            end
            core_result = core_done ? res_hold : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [131:0] snap;
        int           b, g0, s0, base, r0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_key = '0; rsp_ready = 1'b1;
        core_delay = 10; hold_req = 1'b0; grant_clr = '0;
        tick(2);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_error}, 0);
        check("rst_core", {core_start, |core_data, |core_key}, 0);
        rst = 1'b0;
        tick(1);

        // Single requester, result A5..
        req_data[128 +: 128] = {16{8'hA5}};
        req_key[256 +: 256]  = '0;
        core_delay = 10;
        req_valid  = 4'b0010;
        wait_idle(200);
        check("single_id", last_id, 1);
        check("single_data", last_data, {16{8'hA5}});
        check("single_err", last_err, 0);

        // All requesters held: fair rotation from a fresh pointer
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        for (int i = 0; i < N; i++) begin
            req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
            req_key[i*256 +: 256]  = {$urandom, $urandom, $urandom, $urandom,
                                      $urandom, $urandom, $urandom, $urandom};
        end
        core_delay = 3;
        base       = grant_log.size();
        g0         = n_grants;
        hold_req   = 1'b1;
        req_valid  = 4'b1111;
        b = 300;
        while (n_grants < g0 + 5 && b > 0) begin tick(1); b--; end
        hold_req  = 1'b0;
        grant_clr = '0;
        req_valid = '0;
        wait_idle(200);
        for (int i = 0; i < 5; i++)
            check("rr_order", (grant_log.size() > base + i) ? grant_log[base + i] : -1, exp_order[i]);

        // Timeout, done on the last RUN cycle, done one cycle too late
        core_delay = -1;
        req_valid  = 4'b0001;
        wait_idle(300);
        check("tmo_err", last_err, 1);
        check("tmo_data", last_data, 0);
        core_delay = TMO - 1;
        req_valid  = 4'b0100;
        wait_idle(300);
        check("edge_done_wins", last_err, 0);
        core_delay = TMO;
        req_valid  = 4'b1000;
        wait_idle(300);
        check("late_done_err", last_err, 1);

        // Backpressure with a second requester waiting
        core_delay = 4;
        rsp_ready  = 1'b0;
        req_valid  = 4'b0101;
        b = 100;
        while (!rsp_valid && b > 0) begin tick(1); b--; end
        check("bp_valid", rsp_valid, 1);
        snap = {rsp_valid, rsp_id, rsp_data, rsp_error};
        g0   = grant_log.size();
        repeat (5) begin
            tick(1);
            check("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_error}, snap);
            check("bp_nogrant", grant_log.size(), g0);
        end
        rsp_ready = 1'b1;
        wait_idle(300);
        check("bp_second_grant", grant_log.size(), g0 + 1);

        // Reset in the middle of RUN
        core_delay = -1;
        s0         = n_starts;
        req_valid  = 4'b0010;
        b = 50;
        while (n_starts == s0 && b > 0) begin tick(1); b--; end
        tick(5);
        r0  = n_rsp;
        rst = 1'b1;
        tick(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_core_key", |core_key, 0);
        check("mid_rst_key_buf", dut.key_buf, 0);
        rst = 1'b0;
        tick(80);
        check("mid_rst_no_rsp", n_rsp, r0);

        // Recovery job after reset: pointer back at 0, only requester 3 asks
        core_delay = 5;
        req_valid  = 4'b1000;
        wait_idle(200);
        check("recover_id", last_id, 3);
        check("recover_err", last_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
